// File: rtl/pin_lock_pkg.sv
// Shared types and default timing for the PIN entry sequencer.
package pin_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_ERROR   = 2'd2,
    ST_LOCKOUT = 2'd3
  } fsm_e;

  localparam int unsigned PIN_LEN = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 3;

  localparam int unsigned DEF_UNLOCK_CYCLES  = 8;
  localparam int unsigned DEF_ERROR_CYCLES   = 4;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
  localparam int unsigned DEF_MAX_TRIES      = 3;
  localparam int unsigned DEF_TIMER_W        = 8;

endpackage

// File: rtl/pin_entry_sequencer_if.sv
// Keypad-side strobes in, digit index and status out.
interface pin_entry_sequencer_if;
  import pin_lock_pkg::*;

  logic             enter;
  logic             correct_digit;
  logic             clear;
  logic [IDX_W-1:0] state;
  logic             unlocked;
  logic             error;
  logic             locked_out;
  logic [CNT_W-1:0] tries_left;

  modport master (
    output enter, correct_digit, clear,
    input  state, unlocked, error, locked_out, tries_left
  );

  modport slave (
    input  enter, correct_digit, clear,
    output state, unlocked, error, locked_out, tries_left
  );
endinterface

// File: rtl/pin_entry_sequencer_phase_timer.sv
// Loadable down-counter shared by the OPEN, ERROR and LOCKOUT phases.
module phase_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pin_entry_sequencer.sv
// Digit-index sequencer: collects four digit verdicts, then runs unlock/error/lockout phases.
module pin_entry_sequencer
  import pin_lock_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned ERROR_CYCLES   = DEF_ERROR_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned MAX_TRIES      = DEF_MAX_TRIES,
  parameter int unsigned TIMER_W        = DEF_TIMER_W
) (
  input  logic                  clk,
  input  logic                  rst,
  pin_entry_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_T    = CNT_W'(MAX_TRIES);

  fsm_e             fsm_q, fsm_d;
  logic [IDX_W-1:0] state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             unlocked_q, unlocked_d;
  logic             error_q, error_d;
  logic             locked_out_q, locked_out_d;
  logic [CNT_W-1:0] tries_q, tries_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;

  phase_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    match_d  = match_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (fsm_q)
      ST_ENTRY: begin
        if (bus.clear) begin
          state_d = '0;
          match_d = 1'b1;
        end else if (bus.enter) begin
          // Index advances regardless of the digit so a wrong one is never revealed early.
          if (state_q == LAST_IDX) begin
            state_d  = '0;
            match_d  = 1'b1;
            tmr_load = 1'b1;
            if (match_q && bus.correct_digit) begin
              fsm_d   = ST_OPEN;
              tmr_val = TIMER_W'(UNLOCK_CYCLES - 1);
              fail_d  = '0;
            end else if (fail_q + CNT_W'(1) == MAX_T) begin
              fsm_d   = ST_LOCKOUT;
              tmr_val = TIMER_W'(LOCKOUT_CYCLES - 1);
            end else begin
              fsm_d   = ST_ERROR;
              tmr_val = TIMER_W'(ERROR_CYCLES - 1);
              fail_d  = fail_q + CNT_W'(1);
            end
          end else begin
            state_d = state_q + IDX_W'(1);
            match_d = match_q & bus.correct_digit;
          end
        end
      end
      ST_OPEN, ST_ERROR: begin
        state_d = '0;
        if (tmr_zero) fsm_d = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        state_d = '0;
        if (tmr_zero) begin
          fsm_d  = ST_ENTRY;
          fail_d = '0;
        end
      end
      default: fsm_d = ST_ENTRY;
    endcase

    // Phase outputs are registered from the next state so they rise with the final enter edge.
    unlocked_d   = (fsm_d == ST_OPEN);
    error_d      = (fsm_d == ST_ERROR);
    locked_out_d = (fsm_d == ST_LOCKOUT);
    tries_d      = MAX_T - fail_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= ST_ENTRY;
      state_q      <= '0;
      match_q      <= 1'b1;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      error_q      <= 1'b0;
      locked_out_q <= 1'b0;
      tries_q      <= MAX_T;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      match_q      <= match_d;
      fail_q       <= fail_d;
      unlocked_q   <= unlocked_d;
      error_q      <= error_d;
      locked_out_q <= locked_out_d;
      tries_q      <= tries_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.error      = error_q;
  assign bus.locked_out = locked_out_q;
  assign bus.tries_left = tries_q;

endmodule
